// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-slot alarm controller beside the clock core.
// Stores NUM_ALARMS alarm times, compares them against the running time on each
// seconds tick, arbitrates simultaneous matches (lowest slot first, others queued
// as pending) and sequences the ring / snooze / dismiss flow.
// Build option: define ALARM_AUTOSNOOZE_EN to make a ring timeout behave like a
// snooze request; by default a ring timeout dismisses the episode.
module alarm_scheduler #(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_1s,
  input  logic [4:0]                    cur_hours,
  input  logic [5:0]                    cur_minutes,
  input  logic [5:0]                    cur_seconds,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_ALARMS)-1:0] wr_slot,
  input  logic [4:0]                    wr_hours,
  input  logic [5:0]                    wr_minutes,
  input  logic                          wr_enable,
  input  logic                          snooze,
  input  logic                          dismiss,
  output logic                          alarm_signal,
  output logic [$clog2(NUM_ALARMS)-1:0] active_slot,
  output logic                          snoozed,
  output logic [1:0]                    snooze_cnt
);

  localparam int SW = $clog2(NUM_ALARMS);
  localparam int TW = $clog2(RING_TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RING    = 2'd1;
  localparam logic [1:0] SNOOZED = 2'd2;

  // Lowest set bit index of a slot vector (0 when empty).
  function automatic logic [SW-1:0] lowest_idx(input logic [NUM_ALARMS-1:0] v);
    logic [SW-1:0] r;
    r = {SW{1'b0}};
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = SW'(i);
      end
    end
    return r;
  endfunction

  // One-hot mask for a slot index.
  function automatic logic [NUM_ALARMS-1:0] slot_oh(input logic [SW-1:0] idx);
    return {{(NUM_ALARMS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Current time plus SNOOZE_MIN minutes, wrapping the hour past 23. Returns {hh, mm}.
  function automatic logic [10:0] snooze_target(input logic [4:0] h, input logic [5:0] m);
    logic [6:0] msum;
    logic [4:0] hn;
    msum = {1'b0, m} + 7'(SNOOZE_MIN);
    if (msum >= 7'd60) begin
      msum = msum - 7'd60;
      hn   = (h == 5'd23) ? 5'd0 : h + 5'd1;
    end else begin
      hn   = h;
    end
    return {hn, msum[5:0]};
  endfunction

  // Slot storage
  logic [4:0]            slot_hours_q   [NUM_ALARMS];
  logic [4:0]            slot_hours_d   [NUM_ALARMS];
  logic [5:0]            slot_minutes_q [NUM_ALARMS];
  logic [5:0]            slot_minutes_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] armed_q, armed_d;

  // Episode state
  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         active_q, active_d;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TW-1:0]         timeout_q, timeout_d;
  logic [4:0]            tgt_hours_q, tgt_hours_d;
  logic [5:0]            tgt_minutes_q, tgt_minutes_d;
  logic                  snooze_prev_q, snooze_prev_d;
  logic                  dismiss_prev_q, dismiss_prev_d;
  logic                  alarm_signal_q, alarm_signal_d;
  logic                  snoozed_q, snoozed_d;

  // Decoded events
  logic [NUM_ALARMS-1:0] match_s;
  logic                  snooze_edge_s;
  logic                  dismiss_edge_s;
  logic                  disarm_active_s;
  logic                  timeout_hit_s;
  logic                  snooze_req_s;
  logic                  timeout_idle_s;
  logic                  target_hit_s;
  logic [TW-1:0]         timeout_inc_s;
  logic [10:0]           target_s;

  // Slot compare against the pre-write contents, qualified by the on-the-minute tick.
  always_comb begin
    match_s = {NUM_ALARMS{1'b0}};
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_s[i] = tick_1s && (cur_seconds == 6'd0) && armed_q[i] &&
                   (slot_hours_q[i] == cur_hours) && (slot_minutes_q[i] == cur_minutes);
    end
  end

  // Input edge detection, disarm-of-active detection, timeout and snooze-target decode.
  always_comb begin
    snooze_prev_d   = snooze;
    dismiss_prev_d  = dismiss;
    snooze_edge_s   = snooze & ~snooze_prev_q;
    dismiss_edge_s  = dismiss & ~dismiss_prev_q;
    disarm_active_s = wr_en && !wr_enable && (wr_slot == active_q) && (state_q != IDLE);
    timeout_inc_s   = timeout_q + TW'(1);
    timeout_hit_s   = tick_1s && (timeout_inc_s == TW'(RING_TIMEOUT));
    target_hit_s    = tick_1s && (cur_seconds == 6'd0) &&
                      (cur_hours == tgt_hours_q) && (cur_minutes == tgt_minutes_q);
    target_s        = snooze_target(cur_hours, cur_minutes);
`ifdef ALARM_AUTOSNOOZE_EN
    snooze_req_s    = snooze_edge_s | timeout_hit_s;
    timeout_idle_s  = 1'b0;
`else
    snooze_req_s    = snooze_edge_s;
    timeout_idle_s  = timeout_hit_s;
`endif
  end

  // Slot write port: a write lands at the next edge regardless of FSM state.
  always_comb begin
    slot_hours_d   = slot_hours_q;
    slot_minutes_d = slot_minutes_q;
    armed_d        = armed_q;
    if (wr_en && (int'(wr_slot) < NUM_ALARMS)) begin
      slot_hours_d[wr_slot]   = wr_hours;
      slot_minutes_d[wr_slot] = wr_minutes;
      armed_d[wr_slot]        = wr_enable;
    end else begin
      armed_d                 = armed_q;
    end
  end

  // Ring / snooze / dismiss sequencing with pending-slot arbitration.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    tgt_hours_d   = tgt_hours_q;
    tgt_minutes_d = tgt_minutes_q;
    case (state_q)
      IDLE: begin
        if (|match_s) begin
          state_d   = RING;
          active_d  = lowest_idx(match_s);
          pending_d = (pending_q | match_s) & ~slot_oh(lowest_idx(match_s));
          cnt_d     = 2'd0;
          timeout_d = {TW{1'b0}};
        end else if (|pending_q) begin
          state_d   = RING;
          active_d  = lowest_idx(pending_q);
          pending_d = pending_q & ~slot_oh(lowest_idx(pending_q));
          cnt_d     = 2'd0;
          timeout_d = {TW{1'b0}};
        end else begin
          state_d   = IDLE;
        end
      end
      RING: begin
        // Other slots queue up; a re-match of the owner is dropped.
        pending_d = (pending_q | match_s) & ~slot_oh(active_q);
        if (disarm_active_s || dismiss_edge_s || timeout_idle_s) begin
          state_d   = IDLE;
          active_d  = {SW{1'b0}};
          cnt_d     = 2'd0;
          timeout_d = {TW{1'b0}};
        end else if (snooze_req_s) begin
          if (int'(cnt_q) < MAX_SNOOZE) begin
            state_d       = SNOOZED;
            cnt_d         = cnt_q + 2'd1;
            timeout_d     = {TW{1'b0}};
            tgt_hours_d   = target_s[10:6];
            tgt_minutes_d = target_s[5:0];
          end else begin
            state_d   = IDLE;
            active_d  = {SW{1'b0}};
            cnt_d     = 2'd0;
            timeout_d = {TW{1'b0}};
          end
        end else if (tick_1s) begin
          timeout_d = timeout_inc_s;
        end else begin
          timeout_d = timeout_q;
        end
      end
      SNOOZED: begin
        pending_d = (pending_q | match_s) & ~slot_oh(active_q);
        if (disarm_active_s || dismiss_edge_s) begin
          state_d   = IDLE;
          active_d  = {SW{1'b0}};
          cnt_d     = 2'd0;
          timeout_d = {TW{1'b0}};
        end else if (target_hit_s) begin
          state_d   = RING;
          timeout_d = {TW{1'b0}};
        end else begin
          state_d   = SNOOZED;
        end
      end
      default: begin
        state_d   = IDLE;
        active_d  = {SW{1'b0}};
        pending_d = {NUM_ALARMS{1'b0}};
        cnt_d     = 2'd0;
        timeout_d = {TW{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the status bits come straight from flops.
  always_comb begin
    alarm_signal_d = (state_d == RING);
    snoozed_d      = (state_d == SNOOZED);
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hours_q[i]   <= 5'd0;
        slot_minutes_q[i] <= 6'd0;
      end
      armed_q        <= {NUM_ALARMS{1'b0}};
      state_q        <= IDLE;
      active_q       <= {SW{1'b0}};
      pending_q      <= {NUM_ALARMS{1'b0}};
      cnt_q          <= 2'd0;
      timeout_q      <= {TW{1'b0}};
      tgt_hours_q    <= 5'd0;
      tgt_minutes_q  <= 6'd0;
      snooze_prev_q  <= 1'b0;
      dismiss_prev_q <= 1'b0;
      alarm_signal_q <= 1'b0;
      snoozed_q      <= 1'b0;
    end else begin
      slot_hours_q   <= slot_hours_d;
      slot_minutes_q <= slot_minutes_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      tgt_hours_q    <= tgt_hours_d;
      tgt_minutes_q  <= tgt_minutes_d;
      snooze_prev_q  <= snooze_prev_d;
      dismiss_prev_q <= dismiss_prev_d;
      alarm_signal_q <= alarm_signal_d;
      snoozed_q      <= snoozed_d;
    end
  end

  assign alarm_signal = alarm_signal_q;
  assign active_slot  = active_q;
  assign snoozed      = snoozed_q;
  assign snooze_cnt   = cnt_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: stimulus pushes the expected output
// tuple {alarm_signal, active_slot, snoozed, snooze_cnt} and the cycle it must
// appear in; a monitor compares every output change against the queue head.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic [4:0] cur_hours = 5'd0;
  logic [5:0] cur_minutes = 6'd0;
  logic [5:0] cur_seconds = 6'd0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_slot = 2'd0;
  logic [4:0] wr_hours = 5'd0;
  logic [5:0] wr_minutes = 6'd0;
  logic       wr_enable = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       alarm_signal;
  logic [1:0] active_slot;
  logic       snoozed;
  logic [1:0] snooze_cnt;

  alarm_scheduler dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_hours(wr_hours), .wr_minutes(wr_minutes),
    .wr_enable(wr_enable), .snooze(snooze), .dismiss(dismiss),
    .alarm_signal(alarm_signal), .active_slot(active_slot),
    .snoozed(snoozed), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [5:0] exp_val_q [$];
  int         exp_cyc_q [$];
  string      exp_name_q [$];
  int         checks = 0;
  int         passes = 0;
  bit         mon_en = 1'b0;

  function automatic logic [5:0] mk(input logic a, input logic [1:0] s,
                                    input logic z, input logic [1:0] c);
    return {a, s, z, c};
  endfunction

  task automatic expect_out(input logic [5:0] v, input int dly, input string nm);
    exp_val_q.push_back(v);
    exp_cyc_q.push_back(cyc_cnt + dly);
    exp_name_q.push_back(nm);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int s, input int h, input int m, input logic en);
    wr_en = 1'b1; wr_slot = 2'(s); wr_hours = 5'(h); wr_minutes = 6'(m); wr_enable = en;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick(input int h, input int m, input int s);
    cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s); tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1; cyc(); dismiss = 1'b0; cyc();
  endtask

  // Monitor: every change of the output tuple is one presentation to check.
  logic [5:0] prev_v;
  bit         started = 1'b0;
  always @(negedge clk) begin
    logic [5:0] now_v;
    logic [5:0] ev;
    int         ec;
    string      en;
    now_v = {alarm_signal, active_slot, snoozed, snooze_cnt};
    if (mon_en && (!started || now_v !== prev_v)) begin
      started = 1'b1;
      checks++;
      if (exp_val_q.size() == 0) begin
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change", now_v, cyc_cnt);
      end else begin
        ev = exp_val_q.pop_front();
        ec = exp_cyc_q.pop_front();
        en = exp_name_q.pop_front();
        if (now_v === ev && cyc_cnt == ec) begin
          passes++;
        end else begin
          $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", en, now_v, cyc_cnt, ev, ec);
        end
      end
      prev_v = now_v;
    end
  end

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 0, "reset_state");
    mon_en = 1'b1;
    cyc();

    // Basic ring and snooze chain up to the limit
    write_slot(0, 7, 0, 1'b1);
    tick(6, 59, 59);
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd0), 1, "basic_ring");
    tick(7, 0, 0);
    tick(7, 0, 20);
    expect_out(mk(1'b0, 2'd0, 1'b1, 2'd1), 1, "snooze1");
    pulse_snooze();
    tick(7, 4, 0);
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd1), 1, "resnooze_ring1");
    tick(7, 5, 0);
    expect_out(mk(1'b0, 2'd0, 1'b1, 2'd2), 1, "snooze2");
    pulse_snooze();
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd2), 1, "resnooze_ring2");
    tick(7, 10, 0);
    expect_out(mk(1'b0, 2'd0, 1'b1, 2'd3), 1, "snooze3");
    pulse_snooze();
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd3), 1, "resnooze_ring3");
    tick(7, 15, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "snooze_limit_idle");
    pulse_snooze();
    write_slot(0, 7, 0, 1'b0);

    // Arbitration between two slots matching together
    write_slot(1, 8, 30, 1'b1);
    write_slot(2, 8, 30, 1'b1);
    expect_out(mk(1'b1, 2'd1, 1'b0, 2'd0), 1, "arb_lowest");
    tick(8, 30, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "arb_dismiss_idle");
    expect_out(mk(1'b1, 2'd2, 1'b0, 2'd0), 2, "arb_pending_ring");
    pulse_dismiss();
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "arb_dismiss2_idle");
    pulse_dismiss();
    write_slot(1, 8, 30, 1'b0);
    write_slot(2, 8, 30, 1'b0);

    // Midnight wrap of the snooze target
    write_slot(3, 23, 58, 1'b1);
    expect_out(mk(1'b1, 2'd3, 1'b0, 2'd0), 1, "wrap_ring");
    tick(23, 58, 0);
    tick(23, 58, 10);
    expect_out(mk(1'b0, 2'd3, 1'b1, 2'd1), 1, "wrap_snooze");
    pulse_snooze();
    tick(0, 2, 0);
    expect_out(mk(1'b1, 2'd3, 1'b0, 2'd1), 1, "wrap_ring_0003");
    tick(0, 3, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "wrap_dismiss");
    pulse_dismiss();
    write_slot(3, 23, 58, 1'b0);

    // Ring timeout after 60 ticks
    write_slot(0, 10, 0, 1'b1);
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd0), 1, "timeout_ring");
    tick(10, 0, 0);
    for (int i = 1; i < 60; i++) tick(10, 0, i);
`ifdef ALARM_AUTOSNOOZE_EN
    expect_out(mk(1'b0, 2'd0, 1'b1, 2'd1), 1, "timeout_autosnooze");
    tick(10, 1, 1);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "autosnooze_dismiss");
    pulse_dismiss();
`else
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "timeout_idle");
    tick(10, 1, 1);
`endif

    // Snooze and dismiss edges together: dismiss wins
    write_slot(1, 11, 0, 1'b1);
    expect_out(mk(1'b1, 2'd1, 1'b0, 2'd0), 1, "both_ring");
    tick(11, 0, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "both_dismiss_wins");
    snooze = 1'b1; dismiss = 1'b1; cyc();
    snooze = 1'b0; dismiss = 1'b0; cyc();

    // Disarming the active slot ends the episode
    write_slot(2, 12, 0, 1'b1);
    expect_out(mk(1'b1, 2'd2, 1'b0, 2'd0), 1, "disarm_ring");
    tick(12, 0, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "disarm_idle");
    write_slot(2, 12, 0, 1'b0);

    // Reset in the middle of an episode
    write_slot(3, 13, 0, 1'b1);
    expect_out(mk(1'b1, 2'd3, 1'b0, 2'd0), 1, "rst_ring");
    tick(13, 0, 0);
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "rst_mid_idle");
    rst = 1'b1; cyc(); rst = 1'b0; cyc();

    // A write in the match cycle: compare uses the pre-write contents
    write_slot(0, 14, 0, 1'b1);
    wr_en = 1'b1; wr_slot = 2'd0; wr_hours = 5'd14; wr_minutes = 6'd0; wr_enable = 1'b0;
    cur_hours = 5'd14; cur_minutes = 6'd0; cur_seconds = 6'd0; tick_1s = 1'b1;
    expect_out(mk(1'b1, 2'd0, 1'b0, 2'd0), 1, "prewrite_ring");
    cyc();
    wr_en = 1'b0; tick_1s = 1'b0;
    expect_out(mk(1'b0, 2'd0, 1'b0, 2'd0), 1, "prewrite_dismiss");
    pulse_dismiss();
    tick(14, 0, 0);

    repeat (5) cyc();
    while (exp_val_q.size() > 0) begin
      checks++;
      $display("FAIL %s: got no output change, required %b at cycle %0d",
               exp_name_q.pop_front(), exp_val_q.pop_front(), exp_cyc_q.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
